// File: rtl/encoder.sv
// Registered 8-to-3 priority encoder with valid and multi-hit flags.
// One cycle latency; outputs are zero whenever no real index is held.
module encoder (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] din,
    input  logic       en,
    output logic [2:0] y,
    output logic       valid,
    output logic       multi
);

    logic [2:0] y_d;
    logic [2:0] y_q;
    logic       valid_d;
    logic       valid_q;
    logic       multi_d;
    logic       multi_q;

    // Next-state: highest set bit wins; disabled or empty input yields all zeros.
    always_comb begin
        y_d     = 3'd0;
        valid_d = 1'b0;
        multi_d = 1'b0;
        if (en == 1'b1) begin
            if (din != 8'd0) begin
                for (int i = 0; i < 8; i++) begin
                    if (din[i]) begin
                        y_d = 3'(i);
                    end
                end
                valid_d = 1'b1;
                // Clearing the lowest set bit leaves something iff two or more were set.
                multi_d = |(din & (din - 8'd1));
            end
        end
    end

    // Output registers with synchronous reset taking priority over the sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            y_q     <= 3'd0;
            valid_q <= 1'b0;
            multi_q <= 1'b0;
        end else begin
            y_q     <= y_d;
            valid_q <= valid_d;
            multi_q <= multi_d;
        end
    end

    assign y     = y_q;
    assign valid = valid_q;
    assign multi = multi_q;

endmodule

// File: tb/tb_encoder.sv
// Self-checking bench for the registered priority encoder.
// Directed scenarios followed by random pairs against a behavioural model.
module tb_encoder;

    logic       clk;
    logic       rst;
    logic [7:0] din;
    logic       en;
    logic [2:0] y;
    logic       valid;
    logic       multi;

    int compared   = 0;
    int mismatched = 0;

    encoder dut (
        .clk   (clk),
        .rst   (rst),
        .din   (din),
        .en    (en),
        .y     (y),
        .valid (valid),
        .multi (multi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: result of the sample taken at the edge with these inputs.
    task automatic model(input logic r, input logic e, input logic [7:0] d,
                         output logic [2:0] ey, output logic ev, output logic em);
        ey = 3'd0;
        ev = 1'b0;
        em = 1'b0;
        if (r !== 1'b1 && e === 1'b1 && d != 8'd0) begin
            for (int i = 7; i >= 0; i--) begin
                if (d[i] === 1'b1) begin
                    ey = 3'(i);
                    break;
                end
            end
            ev = 1'b1;
            em = ($countones(d) >= 2);
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply one input set, then check outputs just after the capturing edge.
    task automatic step(input string tag, input logic r, input logic e, input logic [7:0] d);
        logic [2:0] ey;
        logic       ev;
        logic       em;
        @(negedge clk);
        rst = r;
        en  = e;
        din = d;
        @(posedge clk);
        #1;
        model(r, e, d, ey, ev, em);
        chk({tag, ".y"},     {5'd0, y},     {5'd0, ey});
        chk({tag, ".valid"}, {7'd0, valid}, {7'd0, ev});
        chk({tag, ".multi"}, {7'd0, multi}, {7'd0, em});
    endtask

    initial begin
        rst = 1'b1;
        en  = 1'b1;
        din = 8'hFF;

        // Reset held two cycles with a full request vector.
        step("rst0", 1'b1, 1'b1, 8'hFF);
        step("rst1", 1'b1, 1'b1, 8'hFF);
        chk("rst.y_const", {5'd0, y}, 8'd0);

        // One-hot sweep.
        for (int i = 0; i < 8; i++) begin
            step($sformatf("onehot%0d", i), 1'b0, 1'b1, 8'(1 << i));
            chk($sformatf("onehot%0d.idx", i), {5'd0, y}, 8'(i));
        end

        // Disable, including an undriven request vector.
        step("dis", 1'b0, 1'b0, 8'b0010_0000);
        step("dis_x", 1'b0, 1'b0, 8'bxxxx_xxxx);
        step("dis_en", 1'b0, 1'b1, 8'b0010_0000);
        chk("dis_en.idx", {5'd0, y}, 8'd5);

        // Priority with several bits set, then empty request.
        step("prio", 1'b0, 1'b1, 8'b0100_1010);
        chk("prio.idx", {5'd0, y}, 8'd6);
        chk("prio.multi1", {7'd0, multi}, 8'd1);
        step("empty", 1'b0, 1'b1, 8'h00);

        // Mid-stream reset pulse.
        step("strm0", 1'b0, 1'b1, 8'h80);
        step("strm_rst", 1'b1, 1'b1, 8'h80);
        step("strm1", 1'b0, 1'b1, 8'h80);
        chk("strm1.idx", {5'd0, y}, 8'd7);

        // Random pairs.
        for (int n = 0; n < 1000; n++) begin
            logic       e;
            logic [7:0] d;
            e = ($urandom_range(0, 3) != 0);
            d = 8'($urandom);
            if ($urandom_range(0, 7) == 0) d = 8'(1 << $urandom_range(0, 7));
            if ($urandom_range(0, 15) == 0) d = 8'h00;
            step("rand", 1'b0, e, d);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
